// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Registered immediate-decode stage for the flintRV front end. Classifies
//   one RV32I/RV64I instruction per transfer, produces the sign-extended
//   XLEN-wide immediate, a format code, an illegal-opcode flag and the
//   PC-relative target pc + imm. One cycle of latency, valid/ready on both
//   sides, synchronous flush.
//
//   Parameters
//     XLEN        datapath width, 32 or 64
//   Ports
//     i_clk       clock, rising edge
//     i_rstn      asynchronous active-low reset
//     i_flush     drop the held entry (and skid entry) plus this cycle's input
//     i_valid     upstream instruction valid
//     o_ready     stage can accept this cycle
//     i_instr     32-bit instruction word
//     i_pc        instruction address
//     o_valid     output valid
//     i_ready     downstream accepts
//     o_imm       sign-extended immediate
//     o_fmt       R=0 I=1 S=2 B=3 U=4 J=5 ILL=7
//     o_target    pc + imm modulo 2^XLEN
//     o_illegal   unrecognised opcode
//
//   Build option
//     IMMDEC_SKID_EN  adds a one-entry skid buffer; o_ready becomes a
//                     registered "skid empty" instead of ~o_valid | i_ready.

module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic [XLEN-1:0] o_target,
    output logic            o_illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_decode_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Decode (combinational, on the incoming instruction)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    entry_t          dec;

    // Signed casts sign-extend from instr[31] to XLEN.
    assign imm_i = XLEN'($signed(i_instr[31:20]));
    assign imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
    assign imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                  i_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({i_instr[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                  i_instr[30:21], 1'b0}));

    always_comb begin
        dec         = '0;
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
        unique case (i_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec.fmt = FMT_I; dec.imm = imm_i; dec.illegal = 1'b0;
            end
            7'b0100011: begin dec.fmt = FMT_S; dec.imm = imm_s; dec.illegal = 1'b0; end
            7'b1100011: begin dec.fmt = FMT_B; dec.imm = imm_b; dec.illegal = 1'b0; end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U; dec.imm = imm_u; dec.illegal = 1'b0;
            end
            7'b1101111: begin dec.fmt = FMT_J; dec.imm = imm_j; dec.illegal = 1'b0; end
            7'b0110011: begin dec.fmt = FMT_R; dec.illegal = 1'b0; end
            // Word-op opcodes only exist on RV64.
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I; dec.imm = imm_i; dec.illegal = 1'b0;
                end
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_R; dec.illegal = 1'b0;
                end
            end
            default: ;
        endcase
        // R and ILL carry imm = 0, so their target is just the PC.
        dec.target = i_pc + dec.imm;
    end

    // ------------------------------------------------------------------
    // Handshake and storage
    // ------------------------------------------------------------------
    logic   out_vld_q, out_vld_d;
    entry_t out_q, out_d;
    logic   in_fire;

    assign in_fire = i_valid & o_ready & ~i_flush;

`ifdef IMMDEC_SKID_EN
    logic   skid_vld_q, skid_vld_d;
    entry_t skid_q, skid_d;

    // Registered ready breaks the combinational path from i_ready.
    assign o_ready = ~skid_vld_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_d      = out_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (i_flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            // Output is necessarily valid here; drain the skid entry in order.
            if (i_ready) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!out_vld_q || i_ready) begin
                out_d     = dec;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = dec;
                skid_vld_d = 1'b1;
            end
        end else if (i_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
        end else begin
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
        end
    end
`else
    assign o_ready = ~out_vld_q | i_ready;

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        if (i_flush) begin
            out_vld_d = 1'b0;
        end else if (in_fire) begin
            // Covers simultaneous in/out: new entry replaces the old one.
            out_d     = dec;
            out_vld_d = 1'b1;
        end else if (i_ready) begin
            out_vld_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    assign o_valid   = out_vld_q;
    assign o_imm     = out_q.imm;
    assign o_fmt     = out_q.fmt;
    assign o_target  = out_q.target;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush = 1'b0;
    logic        vin = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;

    logic        rdy32, v32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, v64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(vin), .o_ready(rdy32),
        .i_instr(instr), .i_pc(pc[31:0]), .o_valid(v32), .i_ready(rdy_in),
        .o_imm(imm32), .o_fmt(fmt32), .o_target(tgt32), .o_illegal(ill32)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_valid(vin), .o_ready(rdy64),
        .i_instr(instr), .i_pc(pc), .o_valid(v64), .i_ready(rdy_in),
        .o_imm(imm64), .o_fmt(fmt64), .o_target(tgt64), .o_illegal(ill64)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } mdl_t;

    typedef struct {
        logic [31:0] imm32, tgt32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64, tgt64;
        logic [2:0]  fmt64;
        logic        ill64;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pop    = 0;

    function automatic mdl_t model(input logic [31:0] ins, input bit is64);
        mdl_t m;
        logic s;
        s = ins[31];
        m = '{imm: 64'd0, fmt: 3'd7, ill: 1'b1};
        case (ins[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011:
                m = '{imm: {{52{s}}, ins[31:20]}, fmt: 3'd1, ill: 1'b0};
            7'b0100011: m = '{imm: {{52{s}}, ins[31:25], ins[11:7]}, fmt: 3'd2, ill: 1'b0};
            7'b1100011: m = '{imm: {{51{s}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0},
                              fmt: 3'd3, ill: 1'b0};
            7'b0110111, 7'b0010111: m = '{imm: {{32{s}}, ins[31:12], 12'h000}, fmt: 3'd4, ill: 1'b0};
            7'b1101111: m = '{imm: {{43{s}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0},
                              fmt: 3'd5, ill: 1'b0};
            7'b0110011: m = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0};
            7'b0011011: if (is64) m = '{imm: {{52{s}}, ins[31:20]}, fmt: 3'd1, ill: 1'b0};
            7'b0111011: if (is64) m = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0};
            default: ;
        endcase
        return m;
    endfunction

    function automatic exp_t expect_of(input logic [31:0] ins, input logic [63:0] p);
        exp_t e;
        mdl_t a, b;
        a = model(ins, 1'b0);
        b = model(ins, 1'b1);
        e.imm32 = a.imm[31:0]; e.fmt32 = a.fmt; e.ill32 = a.ill;
        e.tgt32 = p[31:0] + a.imm[31:0];
        e.imm64 = b.imm; e.fmt64 = b.fmt; e.ill64 = b.ill;
        e.tgt64 = p + b.imm;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if ({v32, imm32, fmt32, tgt32, ill32} !== '0)
            $display("FAIL reset_out32: got v=%b imm=%h fmt=%0d tgt=%h ill=%b, want all 0",
                     v32, imm32, fmt32, tgt32, ill32);
        else n_pass++;
        n_checks++;
        if ({v64, imm64, fmt64, tgt64, ill64} !== '0)
            $display("FAIL reset_out64: got v=%b imm=%h fmt=%0d tgt=%h ill=%b, want all 0",
                     v64, imm64, fmt64, tgt64, ill64);
        else n_pass++;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rdy32 !== 1'b1 || v32 !== 1'b0)
            $display("FAIL reset_ready: got rdy=%b v=%b, want rdy=1 v=0", rdy32, v32);
        else n_pass++;
        tick();
    endtask

    task automatic test_formats();
        logic [31:0] ins_t [7] = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h0010006F,
                                   32'h00000000, 32'hFE112C23, 32'h002081B3};
        logic [31:0] pc_t  [7] = '{32'h100, 32'h1000, 32'h40, 32'h2000, 32'h300, 32'h500, 32'h600};
        logic [31:0] imm_t [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h800,
                                   32'h0, 32'hFFFFFFF8, 32'h0};
        logic [2:0]  fmt_t [7] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd7, 3'd2, 3'd0};
        logic [31:0] tgt_t [7] = '{32'hFF, 32'hFFC, 32'h12345040, 32'h2800,
                                   32'h300, 32'h4F8, 32'h600};
        logic [63:0] imm64_t [7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                                     64'h800, 64'h0, 64'hFFFFFFFFFFFFFFF8, 64'h0};
        rdy_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            vin = 1'b1; instr = ins_t[i]; pc = {32'd0, pc_t[i]};
            tick();
            vin = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({v32, imm32, fmt32, tgt32, ill32} !== {1'b1, imm_t[i], fmt_t[i], tgt_t[i], fmt_t[i] == 3'd7})
                $display("FAIL fmt32[%0d]: got v=%b imm=%h fmt=%0d tgt=%h ill=%b, want imm=%h fmt=%0d tgt=%h",
                         i, v32, imm32, fmt32, tgt32, ill32, imm_t[i], fmt_t[i], tgt_t[i]);
            else n_pass++;
            n_checks++;
            if ({v64, imm64, fmt64} !== {1'b1, imm64_t[i], fmt_t[i]})
                $display("FAIL fmt64[%0d]: got v=%b imm=%h fmt=%0d, want imm=%h fmt=%0d",
                         i, v64, imm64, fmt64, imm64_t[i], fmt_t[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_rv64_ops();
        // addiw x1,x0,1 and addw: legal only on the 64-bit instance.
        logic [31:0] ins_t [2] = '{32'h0010009B, 32'h002081BB};
        logic [2:0]  f64_t [2] = '{3'd1, 3'd0};
        logic [63:0] i64_t [2] = '{64'd1, 64'd0};
        rdy_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vin = 1'b1; instr = ins_t[i]; pc = 64'h8000;
            tick();
            vin = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({ill32, fmt32, imm32, tgt32} !== {1'b1, 3'd7, 32'd0, 32'h8000})
                $display("FAIL w32[%0d]: got ill=%b fmt=%0d imm=%h tgt=%h, want ill=1 fmt=7 imm=0 tgt=8000",
                         i, ill32, fmt32, imm32, tgt32);
            else n_pass++;
            n_checks++;
            if ({ill64, fmt64, imm64, tgt64} !== {1'b0, f64_t[i], i64_t[i], 64'h8000 + i64_t[i]})
                $display("FAIL w64[%0d]: got ill=%b fmt=%0d imm=%h tgt=%h, want ill=0 fmt=%0d imm=%h",
                         i, ill64, fmt64, imm64, tgt64, f64_t[i], i64_t[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prog [4] = '{32'h00500113, 32'hFE112C23, 32'h0010006F, 32'hFE000EE3};
        int sent = 0;
        int start = n_pop;
        int cyc = 0;
        while ((sent < 4 || n_pop - start < 4) && cyc < 40) begin
            rdy_in = !(cyc >= 1 && cyc <= 3);
            vin    = (sent < 4);
            instr  = prog[sent < 4 ? sent : 3];
            pc     = 64'h4000 + 64'(sent * 4);
            @(negedge clk);
`ifdef IMMDEC_SKID_EN
            if (cyc == 1 || cyc == 2) begin
                n_checks++;
                if (rdy32 !== (cyc == 1))
                    $display("FAIL b2b_ready[%0d]: got %b, want %b", cyc, rdy32, cyc == 1);
                else n_pass++;
            end
`else
            if (cyc >= 1 && cyc <= 3) begin
                n_checks++;
                if (rdy32 !== 1'b0)
                    $display("FAIL b2b_ready[%0d]: got %b, want 0", cyc, rdy32);
                else n_pass++;
            end
`endif
            if (vin && rdy32) sent++;
            tick();
            cyc++;
        end
        vin = 1'b0;
        n_checks++;
        if (n_pop - start !== 4 || sent !== 4)
            $display("FAIL b2b_count: got %0d out / %0d in, want 4 / 4", n_pop - start, sent);
        else n_pass++;
    endtask

    task automatic test_flush();
        rdy_in = 1'b0;
        vin = 1'b1; instr = 32'h00A00093; pc = 64'h10;
        tick();
        instr = 32'h00B00093; pc = 64'h14;
        tick();
        instr = 32'h00C00093; pc = 64'h18; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (v32 !== 1'b1)
            $display("FAIL flush_pre: got v=%b, want 1", v32);
        else n_pass++;
        tick();
        flush = 1'b0; vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({v32, v64, rdy32} !== 3'b001)
            $display("FAIL flush_post: got v32=%b v64=%b rdy=%b, want 0 0 1", v32, v64, rdy32);
        else n_pass++;
        tick();
        rdy_in = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (v32 !== 1'b0)
            $display("FAIL flush_drain: got v=%b, want 0", v32);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        rdy_in = 1'b0;
        vin = 1'b1; instr = 32'hFFF00093; pc = 64'h100;
        tick();
        vin = 1'b0;
        @(negedge clk);
        n_checks++;
        if (v32 !== 1'b1)
            $display("FAIL areset_pre: got v=%b, want 1", v32);
        else n_pass++;
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        n_checks++;
        if ({v32, imm32, fmt32, tgt32, ill32, v64, imm64, fmt64, tgt64, ill64} !== '0)
            $display("FAIL areset_out: got v=%b imm=%h fmt=%0d tgt=%h / v=%b imm=%h, want all 0",
                     v32, imm32, fmt32, tgt32, v64, imm64);
        else n_pass++;
        @(posedge clk); #1;
        rstn = 1'b1; rdy_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (v32 !== 1'b0 || rdy32 !== 1'b1)
            $display("FAIL areset_post: got v=%b rdy=%b, want 0 1", v32, rdy32);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [14] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
                                 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                 7'b0110011, 7'b0011011, 7'b0111011, 7'b1111111};
        logic [31:0] r;
        for (int c = 0; c < 400; c++) begin
            r      = $urandom();
            vin    = ($urandom_range(0, 3) != 0);
            instr  = {r[31:7], ops[$urandom_range(0, 13)]};
            pc     = {$urandom(), $urandom()};
            rdy_in = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 29) == 0);
            tick();
        end
        vin = 1'b0; flush = 1'b0; rdy_in = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (q.size() !== 0)
            $display("FAIL rand_drain: got %0d entries left, want 0", q.size());
        else n_pass++;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rstn) begin
                    q.delete();
                end else begin
                    n_checks++;
                    if ({v64, rdy64} !== {v32, rdy32})
                        $display("FAIL lockstep: got v64=%b rdy64=%b, want %b %b", v64, rdy64, v32, rdy32);
                    else n_pass++;
                    if (v32) begin
                        n_checks++;
                        if (q.size() == 0) begin
                            $display("FAIL sb_unexpected: got output imm=%h, want none", imm32);
                        end else begin
                            if ({imm32, tgt32, fmt32, ill32} !== {q[0].imm32, q[0].tgt32, q[0].fmt32, q[0].ill32})
                                $display("FAIL sb32: got imm=%h tgt=%h fmt=%0d ill=%b, want imm=%h tgt=%h fmt=%0d ill=%b",
                                         imm32, tgt32, fmt32, ill32, q[0].imm32, q[0].tgt32, q[0].fmt32, q[0].ill32);
                            else n_pass++;
                            n_checks++;
                            if ({imm64, tgt64, fmt64, ill64} !== {q[0].imm64, q[0].tgt64, q[0].fmt64, q[0].ill64})
                                $display("FAIL sb64: got imm=%h tgt=%h fmt=%0d ill=%b, want imm=%h tgt=%h fmt=%0d ill=%b",
                                         imm64, tgt64, fmt64, ill64, q[0].imm64, q[0].tgt64, q[0].fmt64, q[0].ill64);
                            else n_pass++;
                            if (rdy_in) begin
                                void'(q.pop_front());
                                n_pop++;
                            end
                        end
                    end
                    if (flush) q.delete();
                    else if (vin && rdy32) q.push_back(expect_of(instr, pc));
                end
            end
        join_none

        test_reset();
        test_formats();
        test_rv64_ops();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage for the flintRV front end. Takes one 32-bit RV32I/RV64I instruction and its PC per transfer, classifies the format, and produces a sign-extended XLEN-wide immediate plus the PC-relative target `pc + imm`. Sits between fetch and execute behind a valid/ready handshake, with synchronous flush for branch redirect. Successor to the combinational immediate generator; adds width generality, a format code, an illegal flag, a target adder and pipelining.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; any other value is a synthesis error.
- `i_clk`  in  1  clock, rising edge.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  synchronous flush: drop held and incoming instructions.
- `i_valid`  in  1  upstream instruction valid.
- `o_ready`  out  1  stage can accept this cycle.
- `i_instr`  in  32  instruction word.
- `i_pc`  in  XLEN  instruction address.
- `o_valid`  out  1  output valid.
- `i_ready`  in  1  downstream accepts.
- `o_imm`  out  XLEN  sign-extended immediate.
- `o_fmt`  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- `o_target`  out  XLEN  `pc + imm` modulo 2^XLEN.
- `o_illegal`  out  1  unrecognised opcode.

## Operation
- Opcode map from `instr[6:0]`:
  - I-type: `0000011`, `0010011`, `1100111`, `0001111`, `1110011`.
  - S-type: `0100011`.
  - B-type: `1100011`.
  - U-type: `0110111`, `0010111`.
  - J-type: `1101111`.
  - R-type: `0110011`, imm = 0.
  - Only when XLEN=64: `0011011` is I-type and `0111011` is R-type.
  - Everything else: fmt=7, `o_illegal`=1, imm=0.
- Immediates use the standard RISC-V bit scatter. B and J immediates have LSB 0. U is `instr[31:12]<<12`. All are sign-extended from `instr[31]` to XLEN. Shift-amount fields are not split out; I-type is returned whole.
- `o_target` = `i_pc + imm` for every format. For R and ILL that is `i_pc`.
- A transfer in occurs when `i_valid & o_ready & ~i_flush`. A transfer out occurs when `o_valid & i_ready`.
- While `o_valid & ~i_ready`, all outputs hold stable.
- Flush has priority over everything. It clears `o_valid` and any buffered entry, and the input in that cycle is discarded.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Throughput is 1 per cycle when `i_ready`=1.
- Reset values:
  - `o_valid`=0, `o_imm`=0, `o_fmt`=0, `o_target`=0, `o_illegal`=0.
  - `o_ready`=1 while `i_rstn` is high and no stall is pending.
- Reset asserted mid-stall clears all state immediately, with no clock needed.
- Without the skid buffer: `o_ready` = `~o_valid | i_ready`, a combinational path from `i_ready`.
- Simultaneous in-transfer and out-transfer: the new entry replaces the old one, with no bubble.

## Configuration
- `IMMDEC_SKID_EN` defined:
  - Adds a one-entry skid buffer, and `o_ready` becomes a registered signal equal to "skid buffer empty".
  - When the stage is stalled and an input arrives, the input goes into the skid buffer and `o_ready` drops on the next cycle.
  - When downstream accepts, the skid entry moves to the output and `o_ready` rises the cycle after.
  - Ordering is preserved. Flush empties both entries.
- `IMMDEC_SKID_EN` undefined: combinational `o_ready` as in Timing; there is no buffer.

## Test plan
- XLEN=32, `i_instr`=0xFFF00093 (addi -1), `i_pc`=0x100, `i_ready`=1:
  - next cycle `o_imm`=0xFFFFFFFF, `o_fmt`=1, `o_target`=0x000000FF.
  - Repeat with XLEN=64: `o_imm`=0xFFFFFFFFFFFFFFFF.
- `i_instr`=0xFE000EE3 (beq -4), `i_pc`=0x1000 → `o_imm`=0xFFFFFFFC, `o_fmt`=3, `o_target`=0xFFC.
- `i_instr`=0x123450B7 (lui) → `o_imm`=0x12345000, `o_fmt`=4.
- `i_instr`=0x0010006F (jal +2048), `i_pc`=0x2000 → `o_imm`=0x800, `o_fmt`=5, `o_target`=0x2800.
- `i_instr`=0x00000000 → `o_illegal`=1, `o_fmt`=7, `o_imm`=0.
- Back-to-back stream of 4 instructions with `i_ready` held low for 3 cycles:
  - no loss or reorder and outputs stable while stalled.
  - With `IMMDEC_SKID_EN`, `o_ready` falls one cycle after the second accept.
  - Pulsing `i_flush` during the stall → `o_valid`=0 next cycle.
  - Pulsing `i_rstn` low mid-stall → all outputs reset asynchronously.
